// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: funct3 access sizes,
// responder FSM states and the latency counter width.
package dmem_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } f3_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Wide enough for LATENCY-1 with LATENCY up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory bus. master = datapath side, slave = responder side.
interface dmem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        access_err;

   modport master (output mem_read, mem_write, funct3, addr, wdata,
                   input  rdata, stall, access_err);
   modport slave  (input  mem_read, mem_write, funct3, addr, wdata,
                   output rdata, stall, access_err);
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and replicated
// write word, and load lane extraction with sign/zero extension.
// Halfword uses only lane[1] and word ignores lane entirely, so unaligned
// H/W requests land on the enclosing aligned half/word.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Select lane, build enables and extend load data by access size.
   always_comb begin
      byte_v = rword[{lane, 3'b000} +: 8];
      half_v = lane[1] ? rword[31:16] : rword[15:0];
      be     = 4'b1111;
      wword  = wdata;
      rdata  = rword;
      case (funct3)
         F3_B, F3_BU: begin
            be    = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
            rdata = (funct3 == F3_B) ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
         end
         F3_H, F3_HU: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
            rdata = (funct3 == F3_H) ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
         end
         default: begin
            be    = 4'b1111;
            wword = wdata;
            rdata = rword;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency load/store service from an internal
// word RAM, stalling the core until the access completes.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag misaligned H/HU/W accesses
// as errors instead of silently aligning them.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

   state_e          state;
   logic [CNT_W-1:0] cnt;
   logic [AW-1:0]   cap_idx;
   logic [1:0]      cap_lane;
   logic [31:0]     cap_wdata;
   logic [2:0]      cap_f3;
   logic            cap_wr;
   logic            cap_err;

   logic            req;
   logic [31:0]     off_in;
   logic            out_of_range;
   logic            misalign;

   logic [31:0]     ram [DEPTH_WORDS];
   logic [31:0]     rword;
   logic [3:0]      be;
   logic [31:0]     wword;
   logic [31:0]     ld_data;

   assign req          = bus.mem_read | bus.mem_write;
   assign off_in       = bus.addr - BASE_ADDR;
   assign out_of_range = ({1'b0, off_in} >= SPAN);

   // Alignment error detection for the incoming request.
   always_comb begin
      misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      case (bus.funct3)
         F3_H, F3_HU: misalign = bus.addr[0];
         F3_W:        misalign = |bus.addr[1:0];
         default:     misalign = 1'b0;
      endcase
`else
      // Lane logic forces H/W onto their aligned container; never an error.
`endif
   end

   // FSM, latency counter and request capture. BUSY leaves when the counter
   // would decrement to zero, giving exactly LATENCY stalled cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_idx   <= '0;
         cap_lane  <= '0;
         cap_wdata <= '0;
         cap_f3    <= '0;
         cap_wr    <= 1'b0;
         cap_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req) begin
               cap_idx   <= off_in[AW+1:2];
               cap_lane  <= bus.addr[1:0];
               cap_wdata <= bus.wdata;
               cap_f3    <= bus.funct3;
               cap_wr    <= bus.mem_write;
               cap_err   <= out_of_range | misalign;
               cnt       <= CNT_W'(LATENCY - 1);
               state     <= (LATENCY == 1) ? DONE : BUSY;
            end
            BUSY: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   dmem_lane_align u_align (
      .funct3 (cap_f3),
      .lane   (cap_lane),
      .wdata  (cap_wdata),
      .rword  (rword),
      .be     (be),
      .wword  (wword),
      .rdata  (ld_data)
   );

   // Store commit on the DONE edge; errored or reset-interrupted stores drop.
   always_ff @(posedge clk) begin
      if (!reset && state == DONE && cap_wr && !cap_err) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) ram[cap_idx][8*i +: 8] <= wword[8*i +: 8];
      end
   end

   assign rword          = ram[cap_idx];
   assign bus.rdata      = (state == DONE && !cap_wr && !cap_err) ? ld_data : 32'h0;
   assign bus.access_err = (state == DONE) & cap_err;
   assign bus.stall      = req & (state != DONE) & ~reset;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// loads/stores against a word-array reference model.
module tb_dmem_responder;

   localparam int          LAT   = 2;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] mdl [DEPTH];

   function automatic logic mdl_bad(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off >= DEPTH * 4) return 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
      if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2) != 0) return 1'b1;
      if (f3 == 3'b010 && (a % 4) != 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w, v;
      if (mdl_bad(f3, a)) return 32'h0;
      w = mdl[((a - BASE) / 4) % DEPTH];
      case (f3)
         3'b000, 3'b100: begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         3'b001, 3'b101: begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic void mdl_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int idx, sh;
      logic [31:0] m;
      if (mdl_bad(f3, a)) return;
      idx = ((a - BASE) / 4) % DEPTH;
      case (f3)
         3'b000: begin sh = 8 * (a % 4);        m = 32'hFF << sh;
                       mdl[idx] = (mdl[idx] & ~m) | ((d & 32'hFF) << sh); end
         3'b001: begin sh = 16 * ((a / 2) % 2); m = 32'hFFFF << sh;
                       mdl[idx] = (mdl[idx] & ~m) | ((d & 32'hFFFF) << sh); end
         default: mdl[idx] = d;
      endcase
   endfunction

   // Drives one request starting just after a rising edge and follows it to
   // its completion cycle; returns completion data and stall statistics.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r, output logic e,
                         output int stalls, output logic leak);
      bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f3;
      bus.addr = a; bus.wdata = d;
      stalls = 0; leak = 1'b0; r = 32'h0; e = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.stall === 1'b1) begin
            stalls++;
            if (bus.rdata !== 32'h0 || bus.access_err !== 1'b0) leak = 1'b1;
         end else begin
            r = bus.rdata; e = bus.access_err;
            break;
         end
      end
      @(posedge clk); #1;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
   endtask

   task automatic test_reset;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'b010;
      bus.addr = 32'h0; bus.wdata = 32'h0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
      n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
      n_tests++; if (bus.access_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.access_err); end
      @(posedge clk); #1;
   endtask

   task automatic test_fill;
      logic [31:0] r, d; logic e, lk; int s;
      for (int i = 0; i < 64; i++) begin
         d = $urandom;
         access(1'b0, 1'b1, 3'b010, BASE + 32'(i * 4), d, r, e, s, lk);
         mdl_store(3'b010, BASE + 32'(i * 4), d);
         n_tests++;
         if (s != LAT || e !== 1'b0 || lk) begin
            n_fail++; $display("FAIL fill[%0d] stalls %0d err %b leak %b exp stalls %0d err 0", i, s, e, lk, LAT);
         end
      end
   endtask

   task automatic test_word;
      logic [31:0] r; logic e, lk; int s;
      access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r, e, s, lk);
      mdl_store(3'b010, 32'h10, 32'hDEADBEEF);
      n_tests++; if (s != LAT) begin n_fail++; $display("FAIL sw_stalls got %0d exp %0d", s, LAT); end
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h exp deadbeef", r); end
      n_tests++; if (s != LAT || e !== 1'b0) begin n_fail++; $display("FAIL lw_timing stalls %0d err %b exp %0d 0", s, e, LAT); end
   endtask

   task automatic test_byte;
      logic [31:0] r; logic e, lk; int s;
      access(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, r, e, s, lk);
      mdl_store(3'b010, 32'h10, 32'h11223344);
      access(1'b0, 1'b1, 3'b000, 32'h13, 32'h80, r, e, s, lk);
      mdl_store(3'b000, 32'h13, 32'h80);
      access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb got %h exp ffffff80", r); end
      access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h exp 00000080", r); end
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'h80223344) begin n_fail++; $display("FAIL lw_after_sb got %h exp 80223344", r); end
   endtask

   task automatic test_half;
      logic [31:0] r; logic e, lk; int s;
      access(1'b0, 1'b1, 3'b001, 32'h12, 32'h9ABC, r, e, s, lk);
      mdl_store(3'b001, 32'h12, 32'h9ABC);
      access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'hFFFF9ABC) begin n_fail++; $display("FAIL lh got %h exp ffff9abc", r); end
      access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'h00009ABC) begin n_fail++; $display("FAIL lhu got %h exp 00009abc", r); end
      access(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'h00003344) begin n_fail++; $display("FAIL lh_low got %h exp 00003344", r); end
   endtask

   task automatic test_range;
      logic [31:0] r; logic e, lk; int s;
      logic [31:0] top;
      top = BASE + 32'(DEPTH * 4);
      access(1'b1, 1'b0, 3'b010, top, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL oor_load data %h err %b exp 0 1", r, e); end
      n_tests++; if (s != LAT) begin n_fail++; $display("FAIL oor_stalls got %0d exp %0d", s, LAT); end
      @(negedge clk);
      n_tests++; if (bus.access_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse got %b exp 0", bus.access_err); end
      @(posedge clk); #1;
      access(1'b0, 1'b1, 3'b010, top, 32'hFFFFFFFF, r, e, s, lk);
      n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_store_err got %b exp 1", e); end
      access(1'b1, 1'b0, 3'b010, BASE, 32'h0, r, e, s, lk);
      n_tests++; if (r !== mdl[0]) begin n_fail++; $display("FAIL oor_store_discard got %h exp %h", r, mdl[0]); end
   endtask

   task automatic test_reset_busy;
      logic [31:0] r; logic e, lk; int s;
      access(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, r, e, s, lk);
      mdl_store(3'b010, 32'h20, 32'hCAFEF00D);
      bus.mem_write = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h20; bus.wdata = 32'h55;
      @(negedge clk);
      n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rb_stall_idle got %b exp 1", bus.stall); end
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rb_stall_reset got %b exp 0", bus.stall); end
      bus.mem_write = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, r, e, s, lk);
      n_tests++; if (r !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rb_prior got %h exp cafef00d", r); end
   endtask

   task automatic test_misalign;
      logic [31:0] r; logic e, lk; int s;
      access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, r, e, s, lk);
`ifdef DMEM_MISALIGN_CHECK_EN
      n_tests++; if (r !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL lw_misalign data %h err %b exp 0 1", r, e); end
`else
      n_tests++; if (r !== 32'hCAFEF00D || e !== 1'b0) begin n_fail++; $display("FAIL lw_misalign data %h err %b exp cafef00d 0", r, e); end
`endif
   endtask

   task automatic test_random;
      logic [31:0] r, a, d, exp_r; logic e, lk, wr, rd, exp_e; logic [2:0] f3; int s;
      for (int i = 0; i < 300; i++) begin
         wr = ($urandom % 2) == 1;
         rd = wr ? (($urandom % 8) == 0) : 1'b1;
         f3 = wr ? 3'($urandom % 3) : 3'($urandom % 8);
         if (($urandom % 10) == 0) a = (($urandom % 2) == 0) ? BASE + 32'(DEPTH * 4) + ($urandom % 64) : BASE - 1 - ($urandom % 16);
         else a = BASE + 32'(($urandom % 64) * 4) + ($urandom % 4);
         d = $urandom;
         exp_e = mdl_bad(f3, a);
         exp_r = mdl_load(f3, a);
         access(rd, wr, f3, a, d, r, e, s, lk);
         if (wr) mdl_store(f3, a, d);
         n_tests++;
         if (e !== exp_e || s != LAT || lk || (!wr && r !== exp_r)) begin
            n_fail++;
            $display("FAIL rand[%0d] rd%b wr%b f3=%0d a=%h data %h err %b stalls %0d leak %b exp data %h err %b stalls %0d",
                     i, rd, wr, f3, a, r, e, s, lk, exp_r, exp_e, LAT);
         end
      end
   endtask

   initial begin
      test_reset;
      test_fill;
      test_word;
      test_byte;
      test_half;
      test_range;
      test_reset_busy;
      test_misalign;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
